state_loader: RTL and testbench

Collects a stream of plaintext bytes into one 16-byte block (rows w, x, y, z, four bytes each) and presents it, with the stepping selects s3/s4, to the column-permutation stage directly downstream. Owns the stepping position: the 2-bit select advances per delivered block, like a rotor, and can be keyed at a block boundary. Valid/ready handshakes are used on both sides, so the permutation stage sees a stable block and stable selects for as long as the block is held.

---
 rtl/state_loader.sv | 124 ++++++++++++
 tb/tb_state_loader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/state_loader.sv
// Gathers 16 plaintext bytes into one block and hands it, with the stepping select, downstream.
// Optional XOR checksum port `chk` is built when STATE_LOADER_CHK_EN is defined.
module state_loader #(
  parameter int unsigned STEP_PERIOD = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         key_load,
  input  logic [1:0]   key,
  input  logic         flush,
  output logic [127:0] state_out,
  output logic         s3,
  output logic         s4,
  output logic         out_valid,
  input  logic         out_ready
`ifdef STATE_LOADER_CHK_EN
  ,
  output logic [7:0]   chk
`endif
);

  localparam int unsigned NBYTES = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BLK_W  = 8;
  localparam int unsigned SEL_W  = 2;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]  byte_cnt_q;
  logic [BLK_W-1:0]  blk_cnt_q;
  logic [SEL_W-1:0]  sel_q;
  logic [BYTE_W-1:0] blk_q [NBYTES];

  logic accept;
  logic handoff;
  logic key_ok;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= FILL;
    else     state_q <= state_d;
  end

  // Next state and per-cycle strobes
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    handoff = 1'b0;
    key_ok  = 1'b0;
    case (state_q)
      FILL: begin
        key_ok = key_load && (byte_cnt_q == '0);
        accept = in_valid && !flush;
        if (accept && (byte_cnt_q == CNT_W'(NBYTES - 1))) state_d = HOLD;
      end
      HOLD: begin
        handoff = out_ready;
        if (out_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  assign in_ready  = (state_q == FILL) && !rst;
  assign out_valid = (state_q == HOLD);
  assign s3        = sel_q[1];
  assign s4        = sel_q[0];

  // Byte slots, fill counter and stepping position
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= '0;
      blk_cnt_q  <= '0;
      sel_q      <= '0;
      for (int i = 0; i < int'(NBYTES); i++) blk_q[i] <= '0;
    end else begin
      if ((state_q == FILL) && flush) begin
        byte_cnt_q <= '0;
      end else if (accept) begin
        blk_q[byte_cnt_q] <= in_byte;
        byte_cnt_q        <= byte_cnt_q + CNT_W'(1);
      end
      // Keying and handoff live in different FSM states, so they never collide
      if (key_ok) begin
        sel_q     <= key;
        blk_cnt_q <= '0;
      end else if (handoff) begin
        if (blk_cnt_q == BLK_W'(STEP_PERIOD - 1)) begin
          blk_cnt_q <= '0;
          sel_q     <= sel_q + SEL_W'(1);
        end else begin
          blk_cnt_q <= blk_cnt_q + BLK_W'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < int'(NBYTES); k++) begin : g_pack
    assign state_out[127-8*k -: 8] = blk_q[k];
  end

`ifdef STATE_LOADER_CHK_EN
  // Running XOR restarts with the first byte of each block
  always_ff @(posedge clk) begin
    if (rst) begin
      chk <= '0;
    end else if ((state_q == FILL) && flush) begin
      chk <= '0;
    end else if (accept) begin
      chk <= (byte_cnt_q == '0) ? in_byte : (chk ^ in_byte);
    end
  end
`endif

endmodule

// File: tb/tb_state_loader.sv
// Bench for state_loader: directed scenarios plus random traffic against a queue-level model.
module tb_state_loader;

  localparam int unsigned STEP = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   in_byte = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         key_load = 1'b0;
  logic [1:0]   key = '0;
  logic         flush = 1'b0;
  logic [127:0] state_out;
  logic         s3;
  logic         s4;
  logic         out_valid;
  logic         out_ready = 1'b0;
`ifdef STATE_LOADER_CHK_EN
  logic [7:0]   chk;
`endif

  state_loader #(.STEP_PERIOD(STEP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key_load  (key_load),
    .key       (key),
    .flush     (flush),
    .state_out (state_out),
    .s3        (s3),
    .s4        (s4),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef STATE_LOADER_CHK_EN
    ,
    .chk       (chk)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: bytes collected so far, current block image, keyed base and deliveries since
  bit         m_hold = 1'b0;
  logic [7:0] m_part[$];
  logic [7:0] m_img[16];
  int         m_key = 0;
  int         m_ndel = 0;

  int n_vec = 0;
  int n_err = 0;
  int exp_sel[8] = '{0, 0, 1, 1, 2, 2, 3, 3};

  function automatic logic [127:0] pack_img();
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = m_img[k];
    return r;
  endfunction

  function automatic logic [7:0] img_xor(input int n);
    logic [7:0] x = '0;
    for (int k = 0; k < n; k++) x ^= m_img[k];
    return x;
  endfunction

  function automatic logic [1:0] model_sel();
    return 2'((m_key + m_ndel / int'(STEP)) % 4);
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [7:0] m_chk = '0;

  // One clock cycle: drive, check in_ready, clock, advance the model, check registered outputs
  task automatic cyc(input bit iv, input logic [7:0] ib, input bit kl, input logic [1:0] k,
                     input bit fl, input bit ordy, input bit rs);
    in_valid = iv; in_byte = ib; key_load = kl; key = k; flush = fl; out_ready = ordy; rst = rs;
    #1;
    check("in_ready", 128'(in_ready), 128'(!rs && !m_hold));
    @(posedge clk);
    #1;
    if (rs) begin
      m_hold = 1'b0;
      m_part.delete();
      m_key = 0;
      m_ndel = 0;
      m_chk = '0;
      foreach (m_img[i]) m_img[i] = '0;
    end else if (!m_hold) begin
      if (kl && m_part.size() == 0) begin
        m_key = int'(k);
        m_ndel = 0;
      end
      if (fl) begin
        m_part.delete();
        m_chk = '0;
      end else if (iv) begin
        m_img[m_part.size()] = ib;
        m_part.push_back(ib);
        m_chk = img_xor(m_part.size());
        if (m_part.size() == 16) begin
          m_part.delete();
          m_hold = 1'b1;
        end
      end
    end else if (ordy) begin
      m_hold = 1'b0;
      m_ndel++;
    end
    check("out_valid", 128'(out_valid), 128'(m_hold));
    check("state_out", state_out, pack_img());
    check("sel", 128'({s3, s4}), 128'(model_sel()));
`ifdef STATE_LOADER_CHK_EN
    check("chk", 128'(chk), 128'(m_chk));
`endif
  endtask

  initial begin
    // Reset with traffic offered: nothing may be accepted
    repeat (3) cyc(1'b1, 8'($urandom), 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    check("rst_state_out", state_out, 128'h0);

    // Bytes 0x00..0x0F back to back
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("blk0_valid", 128'(out_valid), 128'd1);
    check("blk0_data", state_out, 128'h000102030405060708090A0B0C0D0E0F);
    check("blk0_sel", 128'({s3, s4}), 128'd0);
`ifdef STATE_LOADER_CHK_EN
    check("blk0_chk", 128'(chk), 128'h0);
`endif
    cyc(1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);

    // Stepping with out_ready tied high, from a fresh reset
    repeat (2) cyc(1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 16; i++) cyc(1'b1, 8'($urandom), 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
      check("step_sel", 128'({s3, s4}), 128'(exp_sel[b]));
      cyc(1'b1, 8'($urandom), 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    end
    check("step_wrap", 128'({s3, s4}), 128'd0);

    // Key with the first byte, then a late key that must be ignored
    cyc(1'b1, 8'($urandom), 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 16; i++) cyc(1'b1, 8'($urandom), (i == 5), 2'b00, 1'b0, 1'b0, 1'b0);
    check("key_sel", 128'({s3, s4}), 128'd3);
    cyc(1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);

    // Flush mid-fill drops the partial block and the byte offered alongside
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'($urandom), 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'hA0 + i), 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("flush_data", state_out, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
`ifdef STATE_LOADER_CHK_EN
    check("flush_chk", 128'(chk), 128'h0);
`endif

    // Stall in HOLD with bytes, keys and flushes offered
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 8'($urandom), (i == 3), 2'b10, (i == 6), 1'b0, 1'b0);
      check("stall_data", state_out, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
    end

    // Reset during HOLD, then a fresh block
    cyc(1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    check("rst_hold_valid", 128'(out_valid), 128'd0);
    check("rst_hold_data", state_out, 128'h0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'($urandom), 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    check("fresh_valid", 128'(out_valid), 128'd1);
    cyc(1'b0, 8'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom % 4) != 0, 8'($urandom), ($urandom % 8) == 0, 2'($urandom),
          ($urandom % 24) == 0, ($urandom % 2) == 0, ($urandom % 250) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
